// File: rtl/hier_call_responder.sv
// ---------------------------------------------------------------------------
// hier_call_responder
//
// Purpose:
//   Target end of the hierarchical function-call path. A caller issues
//   requests (function, instance index, argument, tag) on behalf of a set of
//   named sub-instances. Each instance owns a 32-bit ASCII name register and
//   a 32-bit parameter register. Every accepted request produces exactly one
//   response, queued in a small in-order FIFO. A sticky stop flag and a
//   saturating mismatch counter record failed CHECK_NAME calls.
//
// Handshake (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A source holds valid and its payload stable until the transfer. The
//   responder's req_ready never depends on req_valid. resp_ready is ignored
//   while resp_valid=0. Head outputs hold stable while resp_valid && !resp_ready.
//
// Ports:
//   clk          sole clock, posedge
//   reset_l      synchronous active-low reset
//   req_valid    request present
//   req_ready    responder accepts a request this cycle
//   req_func     0=GET_NAME 1=GET_PARAM 2=CHECK_NAME 3=SET_NAME 4=SET_PARAM
//   req_inst     target instance index
//   req_arg      compare value or write data
//   req_tag      opaque tag echoed in the response
//   resp_valid   response at FIFO head
//   resp_ready   consumer accepts the head response
//   resp_data    result value (0 on error)
//   resp_tag     tag of the answered request
//   resp_err     illegal function or out-of-range instance
//   stop_o       sticky flag, set by any CHECK_NAME mismatch
//   mismatch_cnt saturating count of CHECK_NAME mismatches
// ---------------------------------------------------------------------------
module hier_call_responder #(
  parameter int NUM_INST = 4,
  parameter int DEPTH    = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_func,
  input  logic [3:0]       req_inst,
  input  logic [31:0]      req_arg,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             stop_o,
  output logic [15:0]      mismatch_cnt
);

  localparam logic [2:0] FUNC_GET_NAME   = 3'd0;
  localparam logic [2:0] FUNC_GET_PARAM  = 3'd1;
  localparam logic [2:0] FUNC_CHECK_NAME = 3'd2;
  localparam logic [2:0] FUNC_SET_NAME   = 3'd3;
  localparam logic [2:0] FUNC_SET_PARAM  = 3'd4;

  localparam int         PTR_W      = $clog2(DEPTH);
  localparam int         CNT_W      = $clog2(DEPTH + 1);
  localparam logic [4:0] NUM_INST_L = 5'(NUM_INST);

  // Register files are sized for the full 4-bit index space so that any
  // req_inst value indexes legally; entries at or above NUM_INST are never
  // written and stay at their reset value.
  logic [31:0]      name_q   [16];
  logic [31:0]      param_q  [16];

  // Response FIFO storage and pointers.
  logic [31:0]      fifo_data_q [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q  [DEPTH];
  logic             fifo_err_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             stop_q;
  logic [15:0]      mism_q;

  // Request decode.
  logic             inst_ok;
  logic             func_ok;
  logic             req_err;
  logic [31:0]      cur_name;
  logic [31:0]      cur_param;
  logic             name_match;
  logic [31:0]      result;
  logic             push;
  logic             pop;
  logic             do_set_name;
  logic             do_set_param;
  logic             do_mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign inst_ok    = ({1'b0, req_inst} < NUM_INST_L);
  assign func_ok    = (req_func <= FUNC_SET_PARAM);
  assign req_err    = !inst_ok || !func_ok;
  assign cur_name   = name_q[req_inst];
  assign cur_param  = param_q[req_inst];
  assign name_match = (req_arg == cur_name);

  // Result always reflects register state before the accepting edge, so the
  // SET_* functions return the old value.
  always_comb begin
    result = 32'h0;
    if (!req_err) begin
      case (req_func)
        FUNC_GET_NAME:   result = cur_name;
        FUNC_GET_PARAM:  result = cur_param;
        FUNC_CHECK_NAME: result = {31'b0, name_match};
        FUNC_SET_NAME:   result = cur_name;
        FUNC_SET_PARAM:  result = cur_param;
        default:         result = 32'h0;
      endcase
    end
  end

  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign req_ready  = reset_l && ((count_q < CNT_W'(DEPTH)) || pop);
  assign push       = req_valid && req_ready;

  assign do_set_name  = push && !req_err && (req_func == FUNC_SET_NAME);
  assign do_set_param = push && !req_err && (req_func == FUNC_SET_PARAM);
  assign do_mismatch  = push && !req_err && (req_func == FUNC_CHECK_NAME)
                        && !name_match;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control and status.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stop_q   <= 1'b0;
      mism_q   <= 16'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_mismatch) begin
        stop_q <= 1'b1;
        if (mism_q != 16'hFFFF) begin
          mism_q <= mism_q + 16'h1;
        end
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= 32'h0;
        fifo_tag_q[i]  <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= result;
      fifo_tag_q[wr_ptr_q]  <= req_tag;
      fifo_err_q[wr_ptr_q]  <= req_err;
    end
  end

  // Instance register files. Reset name is "m<digit>  ", param is the index.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      for (int i = 0; i < 16; i++) begin
        name_q[i]  <= {8'h6D, 8'(8'h30 + i), 8'h20, 8'h20};
        param_q[i] <= 32'(i);
      end
    end else begin
      if (do_set_name) begin
        name_q[req_inst] <= req_arg;
      end
      if (do_set_param) begin
        param_q[req_inst] <= req_arg;
      end
    end
  end

  // Head outputs read as zero while the FIFO is empty.
  assign resp_data    = resp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign resp_tag     = resp_valid ? fifo_tag_q[rd_ptr_q]  : '0;
  assign resp_err     = resp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;
  assign stop_o       = stop_q;
  assign mismatch_cnt = mism_q;

endmodule

// File: tb/tb_hier_call_responder.sv
// ---------------------------------------------------------------------------
// tb_hier_call_responder
//
// Directed bench for hier_call_responder (NUM_INST=4, DEPTH=2, TAG_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_hier_call_responder;

  localparam int TAG_W = 4;

  logic             clk;
  logic             reset_l;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_func;
  logic [3:0]       req_inst;
  logic [31:0]      req_arg;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             stop_o;
  logic [15:0]      mismatch_cnt;

  int n_checks;
  int n_fail;

  logic [TAG_W-1:0] exp_q[$];

  hier_call_responder #(
    .NUM_INST(4),
    .DEPTH   (2),
    .TAG_W   (TAG_W)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_func    (req_func),
    .req_inst    (req_inst),
    .req_arg     (req_arg),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag),
    .resp_err    (resp_err),
    .stop_o      (stop_o),
    .mismatch_cnt(mismatch_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] f, input logic [3:0] inst,
                           input logic [31:0] arg, input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_func  = f;
    req_inst  = inst;
    req_arg   = arg;
    req_tag   = tag;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_func  = 3'd0;
    req_inst  = 4'd0;
    req_arg   = 32'h0;
    req_tag   = '0;
  endtask

  task automatic test_reset();
    reset_l    = 1'b0;
    resp_ready = 1'b0;
    idle();
    repeat (3) step();
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready_low: got %b expected 0", req_ready);
    end
    reset_l = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready_release: got %b expected 1", req_ready);
    end
    n_checks++;
    if ({resp_valid, resp_data, resp_tag, resp_err} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_resp: got v=%b d=%h t=%h e=%b expected all zero",
                         resp_valid, resp_data, resp_tag, resp_err);
    end
    n_checks++;
    if ({stop_o, mismatch_cnt} !== 17'h0) begin
      n_fail++; $display("FAIL reset_stop_cnt: got stop=%b cnt=%0d expected 0/0",
                         stop_o, mismatch_cnt);
    end
  endtask

  task automatic test_get();
    resp_ready = 1'b1;
    drive_req(3'd0, 4'd2, 32'h0, 4'd5);
    step();
    n_checks++;
    if ({resp_valid, resp_data, resp_tag, resp_err} !== {1'b1, 32'h6D32_2020, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL get_name_2: got v=%b d=%h t=%h e=%b expected 1/6d322020/5/0",
                         resp_valid, resp_data, resp_tag, resp_err);
    end
    drive_req(3'd1, 4'd3, 32'h0, 4'd6);
    step();
    idle();
    n_checks++;
    if ({resp_valid, resp_data, resp_tag} !== {1'b1, 32'd3, 4'd6}) begin
      n_fail++; $display("FAIL get_param_3: got v=%b d=%h t=%h expected 1/00000003/6",
                         resp_valid, resp_data, resp_tag);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL get_drained: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_set_name();
    drive_req(3'd3, 4'd1, 32'h6D62_2020, 4'd1);
    step();
    n_checks++;
    if (resp_data !== 32'h6D31_2020) begin
      n_fail++; $display("FAIL set_name_old: got %h expected 6d312020", resp_data);
    end
    drive_req(3'd0, 4'd1, 32'h0, 4'd2);
    step();
    idle();
    n_checks++;
    if ({resp_data, resp_tag} !== {32'h6D62_2020, 4'd2}) begin
      n_fail++; $display("FAIL set_name_new: got %h/%h expected 6d622020/2", resp_data, resp_tag);
    end
    step();
  endtask

  task automatic test_set_param();
    drive_req(3'd4, 4'd2, 32'hDEAD_BEEF, 4'd3);
    step();
    n_checks++;
    if (resp_data !== 32'd2) begin
      n_fail++; $display("FAIL set_param_old: got %h expected 00000002", resp_data);
    end
    drive_req(3'd1, 4'd2, 32'h0, 4'd4);
    step();
    idle();
    n_checks++;
    if (resp_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL set_param_new: got %h expected deadbeef", resp_data);
    end
    step();
  endtask

  task automatic test_check();
    drive_req(3'd2, 4'd0, 32'h6D30_2020, 4'd3);
    step();
    n_checks++;
    if ({resp_data, stop_o, mismatch_cnt} !== {32'd1, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL check_match: got d=%h stop=%b cnt=%0d expected 1/0/0",
                         resp_data, stop_o, mismatch_cnt);
    end
    drive_req(3'd2, 4'd0, 32'h6D58_2020, 4'd4);
    step();
    n_checks++;
    if ({resp_data, stop_o, mismatch_cnt} !== {32'd0, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL check_mismatch: got d=%h stop=%b cnt=%0d expected 0/1/1",
                         resp_data, stop_o, mismatch_cnt);
    end
    drive_req(3'd2, 4'd0, 32'h6D30_2020, 4'd5);
    step();
    idle();
    n_checks++;
    if ({resp_data, stop_o, mismatch_cnt} !== {32'd1, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL check_sticky: got d=%h stop=%b cnt=%0d expected 1/1/1",
                         resp_data, stop_o, mismatch_cnt);
    end
    step();
  endtask

  task automatic test_back_pressure();
    logic [TAG_W-1:0] exp_tag;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(TAG_W'(i));
    drive_req(3'd1, 4'd0, 32'h0, 4'd0);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready0: got %b expected 1", req_ready);
    end
    step();
    drive_req(3'd1, 4'd1, 32'h0, 4'd1);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready1: got %b expected 1", req_ready);
    end
    step();
    drive_req(3'd1, 4'd3, 32'h0, 4'd2);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got %b expected 0", req_ready);
    end
    step();
    n_checks++;
    if ({req_ready, resp_valid, resp_tag} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL bp_hold: got rdy=%b v=%b t=%h expected 0/1/0",
                         req_ready, resp_valid, resp_tag);
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_push_pop_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      exp_tag = exp_q.pop_front();
      n_checks++;
      if ({resp_valid, resp_tag} !== {1'b1, exp_tag}) begin
        n_fail++; $display("FAIL bp_order_%0d: got v=%b t=%h expected 1/%h",
                           i, resp_valid, resp_tag, exp_tag);
      end
      step();
      idle();
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: got %b expected 0 (third request lost or duplicated)",
                         resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    // GET_NAME 0..3 on consecutive cycles; instance 1 still holds "mb  ".
    logic [31:0] names [4];
    names[0] = 32'h6D30_2020; names[1] = 32'h6D62_2020;
    names[2] = 32'h6D32_2020; names[3] = 32'h6D33_2020;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(3'd0, 4'(i), 32'h0, TAG_W'(i + 8));
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, req_ready);
      end
      step();
      n_checks++;
      if ({resp_valid, resp_data, resp_tag} !== {1'b1, names[i], TAG_W'(i + 8)}) begin
        n_fail++; $display("FAIL b2b_resp_%0d: got v=%b d=%h t=%h expected 1/%h/%h",
                           i, resp_valid, resp_data, resp_tag, names[i], TAG_W'(i + 8));
      end
    end
    idle();
    step();
  endtask

  task automatic test_errors();
    resp_ready = 1'b1;
    drive_req(3'd0, 4'd4, 32'h0, 4'd7);
    step();
    n_checks++;
    if ({resp_err, resp_data, resp_tag} !== {1'b1, 32'h0, 4'd7}) begin
      n_fail++; $display("FAIL err_inst: got e=%b d=%h t=%h expected 1/0/7",
                         resp_err, resp_data, resp_tag);
    end
    drive_req(3'd6, 4'd0, 32'h0, 4'd8);
    step();
    n_checks++;
    if ({resp_err, resp_data, resp_tag} !== {1'b1, 32'h0, 4'd8}) begin
      n_fail++; $display("FAIL err_func6: got e=%b d=%h t=%h expected 1/0/8",
                         resp_err, resp_data, resp_tag);
    end
    drive_req(3'd5, 4'd0, 32'h0, 4'd9);
    step();
    n_checks++;
    if ({resp_err, resp_data} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_func5: got e=%b d=%h expected 1/0", resp_err, resp_data);
    end
    // Out-of-range SET_NAME and CHECK_NAME must not touch state.
    drive_req(3'd3, 4'd15, 32'h1111_2222, 4'd10);
    step();
    drive_req(3'd2, 4'd5, 32'h0, 4'd11);
    step();
    n_checks++;
    if ({resp_err, mismatch_cnt, stop_o} !== {1'b1, 16'd1, 1'b1}) begin
      n_fail++; $display("FAIL err_no_count: got e=%b cnt=%0d stop=%b expected 1/1/1",
                         resp_err, mismatch_cnt, stop_o);
    end
    drive_req(3'd0, 4'd0, 32'h0, 4'd12);
    step();
    idle();
    n_checks++;
    if ({resp_err, resp_data, resp_tag} !== {1'b0, 32'h6D30_2020, 4'd12}) begin
      n_fail++; $display("FAIL err_after_get: got e=%b d=%h t=%h expected 0/6d302020/c",
                         resp_err, resp_data, resp_tag);
    end
    step();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    drive_req(3'd3, 4'd0, 32'h1234_5678, 4'd1);
    step();
    drive_req(3'd0, 4'd0, 32'h0, 4'd2);
    step();
    idle();
    n_checks++;
    if ({resp_valid, req_ready} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_queued: got v=%b rdy=%b expected 1/0", resp_valid, req_ready);
    end
    reset_l = 1'b0;
    step();
    n_checks++;
    if ({req_ready, resp_valid, resp_data, resp_tag, resp_err, stop_o, mismatch_cnt}
        !== {1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL mid_reset_state: got rdy=%b v=%b d=%h t=%h e=%b stop=%b cnt=%0d expected all zero",
                         req_ready, resp_valid, resp_data, resp_tag, resp_err, stop_o, mismatch_cnt);
    end
    reset_l    = 1'b1;
    resp_ready = 1'b1;
    drive_req(3'd0, 4'd0, 32'h0, 4'd3);
    step();
    drive_req(3'd1, 4'd2, 32'h0, 4'd4);
    n_checks++;
    if ({resp_valid, resp_data, resp_tag} !== {1'b1, 32'h6D30_2020, 4'd3}) begin
      n_fail++; $display("FAIL mid_name_restored: got v=%b d=%h t=%h expected 1/6d302020/3",
                         resp_valid, resp_data, resp_tag);
    end
    step();
    idle();
    n_checks++;
    if (resp_data !== 32'd2) begin
      n_fail++; $display("FAIL mid_param_restored: got %h expected 00000002", resp_data);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_get();
    test_set_name();
    test_set_param();
    test_check();
    test_back_pressure();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
